// File: rtl/ppg_pkg.sv
// ppg_pkg -- shared constants, FSM state type and midpoint helper for the
// PPG AC/DC extractor.
//   ADC_W   : width of one ADC sample (8)
//   CNT_W   : width of the window sample counter (10)
//   state_t : acquisition FSM state (IDLE / ACQ)
package ppg_pkg;

  localparam int ADC_W = 8;
  localparam int CNT_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_t;

  // (a+b)>>1 with a carry bit so that 255+255 does not wrap.
  function automatic logic [ADC_W-1:0] midpoint(input logic [ADC_W-1:0] a,
                                                input logic [ADC_W-1:0] b);
    logic [ADC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return ADC_W'(sum >> 1);
  endfunction

endpackage

// File: rtl/ppg_minmax_tracker.sv
// ppg_minmax_tracker -- running maximum/minimum of one ADC channel.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   start     : the sample presented with valid is the first of a window
//   valid     : a sample is accepted this cycle
//   sample    : ADC sample
//   max, min  : extremes of the window INCLUDING this cycle's sample, so the
//               parent can capture a finished window on the same edge that
//               accepts its last sample.
module ppg_minmax_tracker
  import ppg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  logic [ADC_W-1:0] sample,
  output logic [ADC_W-1:0] max,
  output logic [ADC_W-1:0] min
);

  logic [ADC_W-1:0] max_q, max_d;
  logic [ADC_W-1:0] min_q, min_d;

  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (valid) begin
      if (start) begin
        // First sample of a window seeds both trackers directly.
        max_d = sample;
        min_d = sample;
      end else begin
        if (sample > max_q) max_d = sample;
        if (sample < min_q) min_d = sample;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign max = max_d;
  assign min = min_d;

endmodule

// File: rtl/ppg_ac_dc_extractor.sv
// ppg_ac_dc_extractor -- per-window AC (max-min) and DC ((max+min)>>1)
// extraction for a RED/IR PPG sample stream.
// Parameters:
//   WINDOW_SAMPLES : accepted samples per window (2..1023)
// Ports:
//   CLK, RST                    : rising-edge clock, asynchronous active-high reset
//   Enable                      : high = acquire, low = idle
//   Sample_valid                : one-cycle strobe for RED_ADC_Value/IR_ADC_Value
//   Result_ready                : downstream consumes the result
//   Result_valid                : result registers hold an unconsumed result
//   RED_AC/RED_DC/IR_AC/IR_DC   : registered window results
//   Overrun                     : sticky, a completed window was dropped
//   RED_SAT/IR_SAT              : (only with PPG_SATURATION_FLAG_EN) a sample
//                                 of the window was 0 or full scale
// Build option: define PPG_SATURATION_FLAG_EN to add the saturation flags.
module ppg_ac_dc_extractor
  import ppg_pkg::*;
#(
  parameter int WINDOW_SAMPLES = 200
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic             Sample_valid,
  input  logic [ADC_W-1:0] RED_ADC_Value,
  input  logic [ADC_W-1:0] IR_ADC_Value,
  input  logic             Result_ready,
  output logic             Result_valid,
  output logic [ADC_W-1:0] RED_AC,
  output logic [ADC_W-1:0] RED_DC,
  output logic [ADC_W-1:0] IR_AC,
  output logic [ADC_W-1:0] IR_DC,
`ifdef PPG_SATURATION_FLAG_EN
  output logic             RED_SAT,
  output logic             IR_SAT,
`endif
  output logic             Overrun
);

  localparam int NCH = 2;  // channel 0 = RED, channel 1 = IR
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic             ovr_q, ovr_d;
  logic [ADC_W-1:0] ac_q [NCH];
  logic [ADC_W-1:0] ac_d [NCH];
  logic [ADC_W-1:0] dc_q [NCH];
  logic [ADC_W-1:0] dc_d [NCH];

  logic             accept;
  logic             win_start;
  logic             win_done;
  logic             load;
  logic [ADC_W-1:0] chan_sample [NCH];
  logic [ADC_W-1:0] chan_max    [NCH];
  logic [ADC_W-1:0] chan_min    [NCH];

  assign chan_sample[0] = RED_ADC_Value;
  assign chan_sample[1] = IR_ADC_Value;

  // Samples are taken only while acquiring and still enabled; the cycle in
  // which Enable drops already belongs to the idle period.
  assign accept    = (state_q == ACQ) && Enable && Sample_valid;
  assign win_start = (cnt_q == '0);
  assign win_done  = accept && (cnt_q == LAST_IDX);
  // A finished window is captured unless an unconsumed result is still held.
  assign load      = win_done && (!rv_q || Result_ready);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      ppg_minmax_tracker u_tracker (
        .clk    (CLK),
        .rst    (RST),
        .start  (win_start),
        .valid  (accept),
        .sample (chan_sample[gi]),
        .max    (chan_max[gi]),
        .min    (chan_min[gi])
      );

      always_comb begin
        ac_d[gi] = ac_q[gi];
        dc_d[gi] = dc_q[gi];
        if (load) begin
          ac_d[gi] = chan_max[gi] - chan_min[gi];
          dc_d[gi] = midpoint(chan_max[gi], chan_min[gi]);
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Enable)  state_d = ACQ;
      ACQ:     if (!Enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Any idle cycle throws away a partial window.
    cnt_d = '0;
    if ((state_q == ACQ) && Enable) begin
      cnt_d = cnt_q;
      if (accept) cnt_d = win_done ? '0 : cnt_q + CNT_W'(1);
    end

    rv_d = rv_q;
    if (load)                      rv_d = 1'b1;
    else if (rv_q && Result_ready) rv_d = 1'b0;

    ovr_d = ovr_q | (win_done && rv_q && !Result_ready);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        ac_q[c] <= '0;
        dc_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      ovr_q   <= ovr_d;
      for (int c = 0; c < NCH; c++) begin
        ac_q[c] <= ac_d[c];
        dc_q[c] <= dc_d[c];
      end
    end
  end

  assign Result_valid = rv_q;
  assign Overrun      = ovr_q;
  assign RED_AC       = ac_q[0];
  assign RED_DC       = dc_q[0];
  assign IR_AC        = ac_q[1];
  assign IR_DC        = dc_q[1];

`ifdef PPG_SATURATION_FLAG_EN
  logic [NCH-1:0] sat_q, sat_d;          // running per-window flag
  logic [NCH-1:0] res_sat_q, res_sat_d;  // flag registered with the result

  always_comb begin
    sat_d     = sat_q;
    res_sat_d = res_sat_q;
    for (int c = 0; c < NCH; c++) begin
      if (accept) begin
        sat_d[c] = (win_start ? 1'b0 : sat_q[c]) |
                   (chan_sample[c] == '0) | (chan_sample[c] == '1);
      end
    end
    if (load) res_sat_d = sat_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_q     <= '0;
      res_sat_q <= '0;
    end else begin
      sat_q     <= sat_d;
      res_sat_q <= res_sat_d;
    end
  end

  assign RED_SAT = res_sat_q[0];
  assign IR_SAT  = res_sat_q[1];
`endif

endmodule

// File: tb/tb_ppg_ac_dc_extractor.sv
// Directed bench for ppg_ac_dc_extractor with WINDOW_SAMPLES = 4.
module tb_ppg_ac_dc_extractor;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Enable = 1'b0;
  logic       Sample_valid = 1'b0;
  logic [7:0] RED_ADC_Value = '0;
  logic [7:0] IR_ADC_Value = '0;
  logic       Result_ready = 1'b0;
  logic       Result_valid;
  logic [7:0] RED_AC, RED_DC, IR_AC, IR_DC;
  logic       Overrun;
`ifdef PPG_SATURATION_FLAG_EN
  logic       RED_SAT, IR_SAT;
`endif

  int n_vec = 0;
  int n_err = 0;

  ppg_ac_dc_extractor #(.WINDOW_SAMPLES(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .Enable        (Enable),
    .Sample_valid  (Sample_valid),
    .RED_ADC_Value (RED_ADC_Value),
    .IR_ADC_Value  (IR_ADC_Value),
    .Result_ready  (Result_ready),
    .Result_valid  (Result_valid),
    .RED_AC        (RED_AC),
    .RED_DC        (RED_DC),
    .IR_AC         (IR_AC),
    .IR_DC         (IR_DC),
`ifdef PPG_SATURATION_FLAG_EN
    .RED_SAT       (RED_SAT),
    .IR_SAT        (IR_SAT),
`endif
    .Overrun       (Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] i);
    Sample_valid  = 1'b1;
    RED_ADC_Value = r;
    IR_ADC_Value  = i;
    tick();
    Sample_valid  = 1'b0;
    $display("sample red=%0d ir=%0d -> valid=%0b red_ac=%0d red_dc=%0d ir_ac=%0d ir_dc=%0d ovr=%0b",
             r, i, Result_valid, RED_AC, RED_DC, IR_AC, IR_DC, Overrun);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    n_vec++;
    if ({Result_valid, Overrun, RED_AC, RED_DC, IR_AC, IR_DC} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%0b ovr=%0b %0d/%0d/%0d/%0d, expected all 0",
               Result_valid, Overrun, RED_AC, RED_DC, IR_AC, IR_DC);
    end
    RST = 1'b0;
    Enable = 1'b1;
    tick();
  endtask

  task automatic test_basic_window();
    send(100, 0);
    send(140, 255);
    send(90, 10);
    n_vec++;
    if (Result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_early_valid: got %0b, expected 0", Result_valid);
    end
    send(120, 20);
    n_vec++;
    if (Result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_latency: Result_valid got %0b, expected 1", Result_valid);
    end
    n_vec++;
    if ({RED_AC, RED_DC, IR_AC, IR_DC} !== {8'd50, 8'd115, 8'd255, 8'd127}) begin
      n_err++;
      $display("FAIL basic_values: got %0d/%0d/%0d/%0d, expected 50/115/255/127",
               RED_AC, RED_DC, IR_AC, IR_DC);
    end
`ifdef PPG_SATURATION_FLAG_EN
    n_vec++;
    if ({RED_SAT, IR_SAT} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_sat: got red=%0b ir=%0b, expected red=0 ir=1", RED_SAT, IR_SAT);
    end
`endif
    Result_ready = 1'b1;
    tick();
    Result_ready = 1'b0;
    n_vec++;
    if (Result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_consume: Result_valid got %0b, expected 0", Result_valid);
    end
  endtask

  task automatic test_overrun();
    send(10, 50); send(20, 50); send(30, 50); send(40, 50);
    send(1, 60);  send(2, 60);  send(3, 60);  send(4, 60);
    n_vec++;
    if ({Result_valid, Overrun} !== 2'b11) begin
      n_err++;
      $display("FAIL overrun_flags: got valid=%0b ovr=%0b, expected 1/1", Result_valid, Overrun);
    end
    n_vec++;
    if ({RED_AC, RED_DC, IR_AC, IR_DC} !== {8'd30, 8'd25, 8'd0, 8'd50}) begin
      n_err++;
      $display("FAIL overrun_held: got %0d/%0d/%0d/%0d, expected 30/25/0/50",
               RED_AC, RED_DC, IR_AC, IR_DC);
    end
  endtask

  task automatic test_rst_mid();
    // Result pending and Overrun set from the previous test.
    send(0, 0);
    send(255, 255);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    n_vec++;
    if ({Result_valid, Overrun, RED_AC, RED_DC, IR_AC, IR_DC} !== 34'd0) begin
      n_err++;
      $display("FAIL rst_async: got valid=%0b ovr=%0b %0d/%0d/%0d/%0d, expected all 0",
               Result_valid, Overrun, RED_AC, RED_DC, IR_AC, IR_DC);
    end
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    send(200, 100); send(210, 90); send(205, 80); send(201, 70);
    n_vec++;
    if ({Result_valid, RED_AC, RED_DC, IR_AC, IR_DC} !== {1'b1, 8'd10, 8'd205, 8'd30, 8'd85}) begin
      n_err++;
      $display("FAIL fresh_after_rst: got valid=%0b %0d/%0d/%0d/%0d, expected 1 10/205/30/85",
               Result_valid, RED_AC, RED_DC, IR_AC, IR_DC);
    end
    send(5, 30); send(9, 30); send(7, 31);
    Result_ready = 1'b1;
    send(6, 30);
    n_vec++;
    if ({Result_valid, Overrun} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_flags: got valid=%0b ovr=%0b, expected 1/0", Result_valid, Overrun);
    end
    n_vec++;
    if ({RED_AC, RED_DC, IR_AC, IR_DC} !== {8'd4, 8'd7, 8'd1, 8'd30}) begin
      n_err++;
      $display("FAIL b2b_values: got %0d/%0d/%0d/%0d, expected 4/7/1/30",
               RED_AC, RED_DC, IR_AC, IR_DC);
    end
    tick();
    Result_ready = 1'b0;
    n_vec++;
    if (Result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_consume: Result_valid got %0b, expected 0", Result_valid);
    end
  endtask

  task automatic test_enable_drop();
    send(255, 0);
    send(3, 9);
    Enable = 1'b0;
    tick();
    send(1, 1);   // ignored while idle
    send(2, 2);
    n_vec++;
    if (Result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_result: Result_valid got %0b, expected 0", Result_valid);
    end
    Enable = 1'b1;
    tick();
    send(77, 77); send(77, 77); send(77, 77);
    n_vec++;
    if (Result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reenable_early: Result_valid got %0b, expected 0", Result_valid);
    end
    send(77, 77);
    n_vec++;
    if ({Result_valid, RED_AC, RED_DC, IR_AC, IR_DC} !== {1'b1, 8'd0, 8'd77, 8'd0, 8'd77}) begin
      n_err++;
      $display("FAIL reenable_values: got valid=%0b %0d/%0d/%0d/%0d, expected 1 0/77/0/77",
               Result_valid, RED_AC, RED_DC, IR_AC, IR_DC);
    end
`ifdef PPG_SATURATION_FLAG_EN
    n_vec++;
    if ({RED_SAT, IR_SAT} !== 2'b00) begin
      n_err++;
      $display("FAIL reenable_sat: got red=%0b ir=%0b, expected 0/0", RED_SAT, IR_SAT);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_overrun();
    test_rst_mid();
    test_back_to_back();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ppg_ac_dc_extractor.md
PPG_AC_DC_EXTRACTOR -- requirements
Module: ppg_ac_dc_extractor

Interface
REQ-001 The block SHALL expose parameter WINDOW_SAMPLES, default 200: number of accepted samples per measurement window, legal range 2..1023.
REQ-002 CLK  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 RST  input  1  reset; asynchronous, active-high.
REQ-004 Enable  input  1  high while the LED controller is in normal operation; low SHALL hold the block idle.
REQ-005 Sample_valid  input  1  one-cycle strobe marking a new RED/IR sample pair.
REQ-006 RED_ADC_Value  input  8  red-channel ADC sample.
REQ-007 IR_ADC_Value  input  8  IR-channel ADC sample.
REQ-008 Result_ready  input  1  downstream accepts the result.
REQ-009 Result_valid  output  1  result registers hold an unconsumed window result.
REQ-010 RED_AC, RED_DC, IR_AC, IR_DC  output  8 each  window amplitude (max-min) and midpoint ((max+min)>>1) per channel.
REQ-011 Overrun  output  1  sticky: a completed window result was dropped.

Function
REQ-012 The FSM SHALL have states IDLE and ACQ; IDLE->ACQ on Enable=1; ACQ->IDLE on Enable=0.
REQ-013 In ACQ, a sample SHALL be accepted only on cycles with Sample_valid=1; the window counter (10 bits) SHALL increment once per accepted sample.
REQ-014 The first accepted sample of a window SHALL load both max and min of its channel directly (no 0/255 seeding).
REQ-015 Subsequent samples SHALL update max if sample>max and min if sample<min, independently per channel.
REQ-016 When the accepted sample is number WINDOW_SAMPLES, the counter SHALL wrap to 0 and the next window SHALL start on the next accepted sample with no gap.
REQ-017 AC SHALL be max-min (8-bit, never negative); DC SHALL be (max+min)>>1 computed with a 9-bit intermediate.
REQ-018 Results SHALL be registered and Result_valid SHALL rise the cycle after the final window sample is accepted (latency 1).
REQ-019 Result_valid SHALL hold, with stable outputs, until a cycle with Result_valid=1 and Result_ready=1.
REQ-020 If a window completes while Result_valid=1 and Result_ready=0, the new result SHALL be discarded, the old result SHALL be kept, and Overrun SHALL be set.
REQ-021 If a window completes in the same cycle that Result_ready=1 consumes the old result, the new result SHALL load and Result_valid SHALL stay 1.
REQ-022 Enable falling mid-window SHALL discard the partial window and clear the counter; a pending result SHALL remain valid until consumed.
REQ-023 Sample_valid in IDLE SHALL be ignored.

Reset
REQ-024 On RST=1 the FSM SHALL enter IDLE and the counter, max/min trackers, all result outputs, Result_valid, and Overrun SHALL be 0, independent of CLK.
REQ-025 RST asserted mid-window SHALL discard the window; after RST falls, acquisition SHALL restart with a fresh window if Enable=1.

Configuration
REQ-026 With macro PPG_SATURATION_FLAG_EN defined, the block SHALL add outputs RED_SAT and IR_SAT (1 bit each), registered with the result, set if any sample in the window was 0 or 255.
REQ-027 Without PPG_SATURATION_FLAG_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package ppg_pkg SHALL hold the ADC width constant (8), the counter width (10), and the FSM state typedef.
REQ-029 A sub-module ppg_minmax_tracker (start, valid, sample -> max, min) SHALL be instantiated once per channel.

Verification
REQ-030 Test: WINDOW_SAMPLES=4, RED samples 100,140,90,120 -> RED_AC=50, RED_DC=115, with Result_valid high one cycle after the 4th strobe.
REQ-031 Test: IR samples 0,255,10,20 -> IR_AC=255, IR_DC=127; with PPG_SATURATION_FLAG_EN defined, IR_SAT=1.
REQ-032 Test: hold Result_ready=0 across two windows -> the first result is held and Overrun=1.
REQ-033 Test: assert Result_ready in the exact cycle the second window completes -> Result_valid stays 1, the new values load, and Overrun stays 0.
REQ-034 Test: drop Enable after 2 of 4 samples, then re-enable and send 4 samples of value 77 -> AC=0, DC=77, with no stale extremes.
REQ-035 Test: pulse RST mid-window -> all outputs read 0 immediately, before the next CLK edge.
